// File: rtl/dt_tree_walker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dt_tree_walker_pkg
// Purpose  : Shared node-word layout, feature geometry, FSM encodings and a
//            node-decode helper for the decision-tree walker.
// Revision : 1.0 - initial release
// ============================================================================
package dt_tree_walker_pkg;

    // Node word field positions
    localparam int C_LEAF_BIT  = 63;
    localparam int C_FEAT_HI   = 55;
    localparam int C_FEAT_LO   = 53;
    localparam int C_THR_HI    = 52;
    localparam int C_THR_LO    = 26;
    localparam int C_RCHILD_HI = 25;
    localparam int C_RCHILD_LO = 18;
    localparam int C_LCHILD_HI = 17;
    localparam int C_LCHILD_LO = 10;

    // Feature vector geometry
    localparam int C_NUM_FEATURES = 6;
    localparam int C_FEAT_W       = 32;
    localparam int C_THR_W        = C_THR_HI - C_THR_LO + 1;

    // Walker FSM encodings
    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_FETCH = 2'd1;
    localparam logic [1:0] C_ST_EVAL  = 2'd2;
    localparam logic [1:0] C_ST_DONE  = 2'd3;

    typedef struct packed {
        logic                is_leaf;
        logic [2:0]          feat_id;
        logic [C_THR_W-1:0]  thr;
        logic [7:0]          rchild;
        logic [7:0]          lchild;
    } node_t;

    function automatic node_t decode_node(input logic [63:0] word);
        node_t n;
        n.is_leaf = word[C_LEAF_BIT];
        n.feat_id = word[C_FEAT_HI:C_FEAT_LO];
        n.thr     = word[C_THR_HI:C_THR_LO];
        n.rchild  = word[C_RCHILD_HI:C_RCHILD_LO];
        n.lchild  = word[C_LCHILD_HI:C_LCHILD_LO];
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dt_tree_walker_threshold_decoder.sv
`default_nettype none
// ============================================================================
// Module   : threshold_decoder
// Purpose  : Splits a node word into its fields and makes the left/right
//            decision for the selected feature value (unsigned compare).
// Revision : 1.0 - initial release
// ============================================================================
module threshold_decoder
    import dt_tree_walker_pkg::*;
(
    input  logic [63:0]          node_word,
    input  logic [C_FEAT_W-1:0]  feat_val,
    output logic                 is_leaf,
    output logic [2:0]           feat_id,
    output logic                 feat_ok,
    output logic [7:0]           lchild,
    output logic [7:0]           rchild,
    output logic                 go_left
);

    node_t w_node;
    logic  w_unused_bits;

    assign w_node  = decode_node(node_word);
    assign is_leaf = w_node.is_leaf;
    assign feat_id = w_node.feat_id;
    assign lchild  = w_node.lchild;
    assign rchild  = w_node.rchild;
    assign feat_ok = (w_node.feat_id < 3'(C_NUM_FEATURES));
    // Threshold is zero-extended to feature width before an unsigned compare
    assign go_left = (feat_val <= {{(C_FEAT_W-C_THR_W){1'b0}}, w_node.thr});

    // Reserved bits and the class field are not needed for the branch decision
    assign w_unused_bits = ^{node_word[62:56], node_word[9:0]};

endmodule
`default_nettype wire

// File: rtl/dt_tree_walker.sv
`default_nettype none
// ============================================================================
// Module   : dt_tree_walker
// Purpose  : Decision-tree traversal engine. Latches a 6-feature vector,
//            walks node memory from the root until a leaf, returns its class
//            and depth, or flags an error on bad feature id / depth limit.
// Revision : 1.0 - initial release
// ============================================================================
module dt_tree_walker
    import dt_tree_walker_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int ROOT_ADDR = 0,
    parameter int MAX_DEPTH = 16,
    parameter int CLASS_W   = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [C_NUM_FEATURES*C_FEAT_W-1:0]  in_feat,
    output logic                                mem_rd_en,
    output logic [ADDR_W-1:0]                   mem_addr,
    input  logic [63:0]                         mem_rdata,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [CLASS_W-1:0]                  out_class,
    output logic [4:0]                          out_depth,
    output logic                                out_err
);

    localparam logic [ADDR_W-1:0] C_ROOT      = ADDR_W'(ROOT_ADDR);
    localparam logic [4:0]        C_LAST_LVL  = 5'(MAX_DEPTH - 1);

    logic [1:0]                          r_state;
    logic [C_NUM_FEATURES*C_FEAT_W-1:0]  r_feat;
    logic [ADDR_W-1:0]                   r_cur_addr;
    logic [4:0]                          r_depth;

    logic [C_FEAT_W-1:0]  w_feat_sel;
    logic                 w_is_leaf;
    logic [2:0]           w_feat_id;
    logic                 w_feat_ok;
    logic [7:0]           w_lchild;
    logic [7:0]           w_rchild;
    logic                 w_go_left;

    assign in_ready  = (r_state == C_ST_IDLE);
    assign mem_rd_en = (r_state == C_ST_FETCH);
    assign mem_addr  = r_cur_addr;

    // Feature mux: pick the feature addressed by the current node (0 if out of range)
    always_comb begin
        w_feat_sel = '0;
        for (int k = 0; k < C_NUM_FEATURES; k++) begin
            if (w_feat_id == 3'(k)) begin
                w_feat_sel = r_feat[k*C_FEAT_W +: C_FEAT_W];
            end
        end
    end

    threshold_decoder u_threshold_decoder (
        .node_word (mem_rdata),
        .feat_val  (w_feat_sel),
        .is_leaf   (w_is_leaf),
        .feat_id   (w_feat_id),
        .feat_ok   (w_feat_ok),
        .lchild    (w_lchild),
        .rchild    (w_rchild),
        .go_left   (w_go_left)
    );

    // Traversal FSM, depth counter and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= C_ST_IDLE;
            r_feat     <= '0;
            r_cur_addr <= C_ROOT;
            r_depth    <= '0;
            out_valid  <= 1'b0;
            out_class  <= '0;
            out_depth  <= '0;
            out_err    <= 1'b0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (in_valid) begin
                        r_feat     <= in_feat;
                        r_cur_addr <= C_ROOT;
                        r_depth    <= '0;
                        r_state    <= C_ST_FETCH;
                    end
                end
                C_ST_FETCH: begin
                    r_state <= C_ST_EVAL;
                end
                C_ST_EVAL: begin
                    out_depth <= r_depth;
                    if (w_is_leaf) begin
                        out_class <= mem_rdata[CLASS_W-1:0];
                        out_err   <= 1'b0;
                        r_state   <= C_ST_DONE;
                    end else if (!w_feat_ok || (r_depth == C_LAST_LVL)) begin
                        out_class <= '0;
                        out_err   <= 1'b1;
                        r_state   <= C_ST_DONE;
                    end else begin
                        r_cur_addr <= ADDR_W'(w_go_left ? w_lchild : w_rchild);
                        r_depth    <= r_depth + 5'd1;
                        r_state    <= C_ST_FETCH;
                    end
                end
                C_ST_DONE: begin
                    // out_valid rises one cycle after entering DONE; handshake only once it is up
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= C_ST_IDLE;
                    end
                end
                default: r_state <= C_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dt_tree_walker.sv
`default_nettype none
// ============================================================================
// Module   : tb_dt_tree_walker
// Purpose  : Directed self-checking bench for dt_tree_walker with a
//            1-cycle synchronous node memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dt_tree_walker;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [191:0] in_feat = '0;
    logic         mem_rd_en;
    logic [7:0]   mem_addr;
    logic [63:0]  mem_rdata = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [1:0]   out_class;
    logic [4:0]   out_depth;
    logic         out_err;

    logic [63:0]  mem [0:255];
    logic [7:0]   rd_log [0:1023];
    int           rd_total = 0;
    int           rd_base  = 0;
    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    dt_tree_walker #(
        .ADDR_W    (8),
        .ROOT_ADDR (0),
        .MAX_DEPTH (16),
        .CLASS_W   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_feat   (in_feat),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_class (out_class),
        .out_depth (out_depth),
        .out_err   (out_err)
    );

    // Node memory: word appears the cycle after the read strobe
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    // Log every read address issued while out of reset
    always @(posedge clk) begin
        if (rst_n && mem_rd_en && rd_total < 1024) begin
            rd_log[rd_total] <= mem_addr;
            rd_total <= rd_total + 1;
        end
    end

    function automatic logic [63:0] mk_leaf(input logic [1:0] c);
        logic [63:0] w;
        w = '0;
        w[63] = 1'b1;
        w[1:0] = c;
        return w;
    endfunction

    function automatic logic [63:0] mk_node(input logic [2:0] fid, input logic [26:0] thr,
                                            input logic [7:0] l, input logic [7:0] r);
        logic [63:0] w;
        w = '0;
        w[55:53] = fid;
        w[52:26] = thr;
        w[25:18] = r;
        w[17:10] = l;
        return w;
    endfunction

    function automatic logic [191:0] mk_feat(input logic [31:0] f0, input logic [31:0] f5);
        return {f5, 32'h7, 32'h7, 32'h7, 32'h7, f0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = mk_leaf(2'd0);
    endtask

    // Present a vector; returns #1 after the accepting edge T
    task automatic start(input logic [191:0] f, input bit keep);
        @(negedge clk);
        check("in_ready_before_accept", in_ready, 1);
        in_feat  = f;
        in_valid = 1'b1;
        rd_base  = rd_total;
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    // Count edges after T until out_valid is seen (bounded)
    task automatic wait_out(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!out_valid && lat < 100);
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_after_hs", out_valid, 0);
        check("in_ready_after_hs", in_ready, 1);
    endtask

    initial begin
        int lat;
        bit seen;
        int path [5];
        path = '{0, 10, 20, 30, 40};
        clear_mem();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_mem_rd_en", mem_rd_en, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_class", out_class, 0);
        check("rst_out_depth", out_depth, 0);
        check("rst_out_err", out_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: root leaf
        mem[0] = mk_leaf(2'd2);
        start(mk_feat(32'h0, 32'h0), 0);
        wait_out(lat);
        check("t1_latency", lat, 3);
        check("t1_class", out_class, 2);
        check("t1_depth", out_depth, 0);
        check("t1_err", out_err, 0);
        handshake();

        // 2: one split on f0, boundary equal goes left
        clear_mem();
        mem[0] = mk_node(3'd0, 27'h100, 8'd1, 8'd2);
        mem[1] = mk_leaf(2'd1);
        mem[2] = mk_leaf(2'd3);
        start(mk_feat(32'h100, 32'h0), 0);
        wait_out(lat);
        check("t2a_latency", lat, 5);
        check("t2a_class", out_class, 1);
        check("t2a_depth", out_depth, 1);
        handshake();
        start(mk_feat(32'h101, 32'h0), 0);
        wait_out(lat);
        check("t2b_latency", lat, 5);
        check("t2b_class", out_class, 3);
        check("t2b_depth", out_depth, 1);
        check("t2b_err", out_err, 0);
        handshake();

        // 3: chain of four nodes on f5, leaf at depth 4
        clear_mem();
        mem[0]  = mk_node(3'd5, 27'h10, 8'd99, 8'd10);
        mem[10] = mk_node(3'd5, 27'h10, 8'd99, 8'd20);
        mem[20] = mk_node(3'd5, 27'h10, 8'd99, 8'd30);
        mem[30] = mk_node(3'd5, 27'h10, 8'd99, 8'd40);
        mem[40] = mk_leaf(2'd2);
        mem[99] = mk_leaf(2'd1);
        start(mk_feat(32'h0, 32'h20), 0);
        wait_out(lat);
        check("t3_latency", lat, 11);
        check("t3_class", out_class, 2);
        check("t3_depth", out_depth, 4);
        check("t3_err", out_err, 0);
        check("t3_rd_pulses", rd_total - rd_base, 5);
        for (int i = 0; i < 5; i++) check($sformatf("t3_path%0d", i), rd_log[rd_base + i], path[i]);
        handshake();

        // 4: self-loop terminates at the depth limit
        clear_mem();
        mem[0] = mk_node(3'd1, 27'h0, 8'd0, 8'd0);
        start(mk_feat(32'h5, 32'h5), 0);
        wait_out(lat);
        check("t4_latency", lat, 33);
        check("t4_err", out_err, 1);
        check("t4_class", out_class, 0);
        check("t4_depth", out_depth, 15);
        check("t4_rd_pulses", rd_total - rd_base, 16);
        handshake();

        // 5: illegal feature id, in_valid held, back-pressure, then next accept
        clear_mem();
        mem[0] = mk_node(3'd7, 27'h0, 8'd1, 8'd2);
        start(mk_feat(32'h1, 32'h1), 1);
        wait_out(lat);
        check("t5_latency", lat, 3);
        check("t5_err", out_err, 1);
        check("t5_class", out_class, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("t5_hold_valid", out_valid, 1);
            check("t5_hold_err", out_err, 1);
            check("t5_hold_class", out_class, 0);
            check("t5_hold_in_ready", in_ready, 0);
        end
        check("t5_rd_pulses", rd_total - rd_base, 1);
        mem[0] = mk_leaf(2'd1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("t5_hs_out_valid", out_valid, 0);
        check("t5_hs_in_ready", in_ready, 1);
        rd_base = rd_total;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t5_accepted", in_ready, 0);
        wait_out(lat);
        check("t5b_latency", lat, 3);
        check("t5b_class", out_class, 1);
        check("t5b_err", out_err, 0);
        handshake();

        // 6: reset during EVAL at depth 2
        clear_mem();
        mem[0]  = mk_node(3'd5, 27'h10, 8'd99, 8'd10);
        mem[10] = mk_node(3'd5, 27'h10, 8'd99, 8'd20);
        mem[20] = mk_node(3'd5, 27'h10, 8'd99, 8'd30);
        mem[30] = mk_node(3'd5, 27'h10, 8'd99, 8'd40);
        mem[40] = mk_leaf(2'd2);
        mem[99] = mk_leaf(2'd1);
        start(mk_feat(32'h0, 32'h20), 0);
        repeat (5) @(posedge clk);
        #1;
        check("t6_pre_addr", mem_addr, 20);
        check("t6_pre_rd_en", mem_rd_en, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_in_ready", in_ready, 1);
        check("t6_rst_rd_en", mem_rd_en, 0);
        check("t6_rst_addr", mem_addr, 0);
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_depth", out_depth, 0);
        check("t6_rst_err", out_err, 0);
        check("t6_rst_class", out_class, 0);
        seen = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        check("t6_no_valid_pulse", seen, 0);
        start(mk_feat(32'h0, 32'h20), 0);
        wait_out(lat);
        check("t6_latency", lat, 11);
        check("t6_class", out_class, 2);
        check("t6_depth", out_depth, 4);
        check("t6_rd_pulses", rd_total - rd_base, 5);
        handshake();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
